rtc_write_bus_driver: RTL and testbench

RTC_WRITE_BUS_DRIVER -- requirements
Module: rtc_write_bus_driver

---
 rtl/rtc_write_bus_driver.sv | 198 +++++++++++++++++++
 tb/tb_rtc_write_bus_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_write_bus_driver.sv
// Write-side bus driver for a multiplexed-address/data RTC: one address and one
// data strobe per field, timed by a shared down-counter. Optional macro: RTC_WR_TIMEOUT_EN.
module rtc_write_bus_driver #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_WR    = 5,
  parameter int unsigned T_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E_esc,
  input  logic [7:0] Dato_Dire,
  output logic       DIR,
  output logic       DAT,
  output logic       cambio_estado,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       AD_sel,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       busy,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE,
    A_PULSE,
    A_LATCH,
    A_SETUP,
    A_WR,
    A_HOLD,
    D_PULSE,
    D_LATCH,
    D_SETUP,
    D_WR,
    D_HOLD,
    NEXT,
    WAIT_LOW
  } state_t;

  // The counter is loaded with duration-1 on entry; the state exits when it reads zero.
  localparam logic [7:0] SETUP_RLD = 8'(T_SETUP - 1);
  localparam logic [7:0] WR_RLD    = 8'(T_WR - 1);
  localparam logic [7:0] HOLD_RLD  = 8'(T_HOLD - 1);
`ifdef RTC_WR_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_RLD = 8'd15;
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ad_out_q;
  logic       ad_sel_q;
  logic       cnt_zero;

  assign cnt_zero = (cnt_q == 8'd0);

`ifdef RTC_WR_TIMEOUT_EN
  logic err_q, err_d;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef RTC_WR_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE:    if (E_esc) state_d = A_PULSE;
      A_PULSE: state_d = A_LATCH;
      A_LATCH: begin
        state_d = A_SETUP;
        cnt_d   = SETUP_RLD;
      end
      A_SETUP: begin
        if (cnt_zero) begin
          state_d = A_WR;
          cnt_d   = WR_RLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      A_WR: begin
        if (cnt_zero) begin
          state_d = A_HOLD;
          cnt_d   = HOLD_RLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      A_HOLD: begin
        if (cnt_zero) state_d = D_PULSE;
        else          cnt_d   = cnt_q - 8'd1;
      end
      D_PULSE: state_d = D_LATCH;
      D_LATCH: begin
        state_d = D_SETUP;
        cnt_d   = SETUP_RLD;
      end
      D_SETUP: begin
        if (cnt_zero) begin
          state_d = D_WR;
          cnt_d   = WR_RLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      D_WR: begin
        if (cnt_zero) begin
          state_d = D_HOLD;
          cnt_d   = HOLD_RLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      D_HOLD: begin
        if (cnt_zero) state_d = NEXT;
        else          cnt_d   = cnt_q - 8'd1;
      end
      NEXT: begin
        state_d = WAIT_LOW;
`ifdef RTC_WR_TIMEOUT_EN
        cnt_d   = TIMEOUT_RLD;
`endif
      end
      WAIT_LOW: begin
        // Waiting for the sequencer's low gap keeps a held-high E_esc from
        // retriggering the same field.
        if (!E_esc) begin
          state_d = IDLE;
`ifdef RTC_WR_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus byte is captured at the exit edge of each latch state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ad_out_q <= 8'h00;
    end else if (state_q == A_LATCH || state_q == D_LATCH) begin
      ad_out_q <= Dato_Dire;
    end
  end

  // Phase select follows the state being entered and holds outside A_*/D_*.
  always_ff @(posedge clk) begin
    if (reset) begin
      ad_sel_q <= 1'b0;
    end else if (state_d inside {[A_PULSE:A_HOLD]}) begin
      ad_sel_q <= 1'b0;
    end else if (state_d inside {[D_PULSE:D_HOLD]}) begin
      ad_sel_q <= 1'b1;
    end
  end

`ifdef RTC_WR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign DIR           = (state_q == A_PULSE);
  assign DAT           = (state_q == D_PULSE);
  assign cambio_estado = (state_q == NEXT);
  assign AD_out        = ad_out_q;
  assign AD_sel        = ad_sel_q;
  assign AD_oe         = state_q inside {A_SETUP, A_WR, A_HOLD, D_SETUP, D_WR, D_HOLD};
  assign CS_n          = !(state_q inside {[A_SETUP:D_HOLD]});
  assign WR_n          = !(state_q == A_WR || state_q == D_WR);
  assign RD_n          = 1'b1;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rtc_write_bus_driver.sv
// Scoreboard bench for rtc_write_bus_driver: a default-timing instance driven by a
// sequencer model, plus a T_*=1 instance for the minimum-timing case.
module tb_rtc_write_bus_driver;

  localparam int T_WR_DEF = 5;

  logic       clk = 1'b0;
  logic       reset, e_esc, e2;
  logic [7:0] dato, d2;

  logic       DIR, DAT, cambio_estado, AD_oe, AD_sel, CS_n, WR_n, RD_n, busy, err;
  logic [7:0] AD_out;
  logic       DIR2, DAT2, cambio2, AD_oe2, AD_sel2, CS_n2, WR_n2, RD_n2, busy2, err2;
  logic [7:0] AD_out2;

  always #5 clk = ~clk;

  rtc_write_bus_driver dut (
    .clk(clk), .reset(reset), .E_esc(e_esc), .Dato_Dire(dato),
    .DIR(DIR), .DAT(DAT), .cambio_estado(cambio_estado), .AD_out(AD_out),
    .AD_oe(AD_oe), .AD_sel(AD_sel), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
    .busy(busy), .err(err)
  );

  rtc_write_bus_driver #(.T_SETUP(1), .T_WR(1), .T_HOLD(1)) dut_fast (
    .clk(clk), .reset(reset), .E_esc(e2), .Dato_Dire(d2),
    .DIR(DIR2), .DAT(DAT2), .cambio_estado(cambio2), .AD_out(AD_out2),
    .AD_oe(AD_oe2), .AD_sel(AD_sel2), .CS_n(CS_n2), .WR_n(WR_n2), .RD_n(RD_n2),
    .busy(busy2), .err(err2)
  );

  typedef struct {
    logic [7:0] ad;
    logic       sel;
    int         len;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  int      done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int dir_cnt  = 0;
  int fidx     = 0;

  logic [7:0] addr_tab [7] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
  logic [7:0] data_tab [7] = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h19, 8'h03, 8'h59};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sequencer model: answers DIR/DAT with the field byte, valid for the latch cycle only.
  initial begin
    bit hold;
    hold = 1'b0;
    dato = 8'hEE;
    forever begin
      @(negedge clk);
      if (DIR) begin
        dato = addr_tab[fidx];
        hold = 1'b1;
      end else if (DAT) begin
        dato = data_tab[fidx];
        hold = 1'b1;
      end else if (hold) begin
        hold = 1'b0;
      end else begin
        dato = 8'hEE;
      end
    end
  end

  // Monitor: pops expectations whenever a write strobe or completion pulse appears.
  initial begin
    logic    wr_prev;
    logic    have_cur;
    wr_exp_t cur;
    int      len;
    wr_prev  = 1'b1;
    have_cur = 1'b0;
    len      = 0;
    cur      = '{8'h00, 1'b0, 0};
    forever begin
      @(negedge clk);
      if (DIR) dir_cnt++;
      if (!WR_n && wr_prev) begin
        wr_cnt++;
        len = 1;
        check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        have_cur = (wr_q.size() != 0);
        if (have_cur) cur = wr_q.pop_front();
      end else if (!WR_n) begin
        len++;
      end else if (!wr_prev && have_cur) begin
        check("wr_len", 32'(len), 32'(cur.len));
        have_cur = 1'b0;
      end
      if (!WR_n && have_cur) begin
        check("wr_ad_out", 32'(AD_out), 32'(cur.ad));
        check("wr_ad_sel", 32'(AD_sel), 32'(cur.sel));
        check("wr_cs_n",   32'(CS_n),   32'd0);
        check("wr_ad_oe",  32'(AD_oe),  32'd1);
      end
      if (cambio_estado) begin
        done_cnt++;
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
      wr_prev = WR_n;
    end
  end

  // Issue one field; E_esc drops for exactly the WAIT_LOW cycle unless it is held.
  task automatic run_field(input int idx, input logic hold_high);
    fidx = idx;
    wr_q.push_back('{addr_tab[idx], 1'b0, T_WR_DEF});
    wr_q.push_back('{data_tab[idx], 1'b1, T_WR_DEF});
    // NEXT is the 23rd cycle after the sampling edge (cyc+1): visible after edge cyc+1+22.
    done_q.push_back(cyc + 1 + 22);
    e_esc = 1'b1;
    for (int i = 0; i < 60 && !cambio_estado; i++) @(negedge clk);
    if (!cambio_estado) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (!hold_high) e_esc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int start;
    int wrlow;
    int cslow;
    int done_at;
    reset = 1'b1;
    e_esc = 1'b0;
    e2    = 1'b0;
    d2    = 8'h5A;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    check("rst_dir",    32'(DIR),           32'd0);
    check("rst_dat",    32'(DAT),           32'd0);
    check("rst_cambio", 32'(cambio_estado), 32'd0);
    check("rst_ad_out", 32'(AD_out),        32'h00);
    check("rst_ad_oe",  32'(AD_oe),         32'd0);
    check("rst_ad_sel", 32'(AD_sel),        32'd0);
    check("rst_cs_n",   32'(CS_n),          32'd1);
    check("rst_wr_n",   32'(WR_n),          32'd1);
    check("rst_rd_n",   32'(RD_n),          32'd1);
    check("rst_busy",   32'(busy),          32'd0);
    check("rst_err",    32'(err),           32'd0);
    check("rst_busy2",  32'(busy2),         32'd0);

    // Single field: 21 then 45.
    run_field(0, 1'b0);
    check("idle_after_field", 32'(busy), 32'd0);

    // Reset during the third cycle of A_WR: strobe is cut to 3 cycles.
    fidx = 1;
    wr_q.push_back('{addr_tab[1], 1'b0, 3});
    e_esc = 1'b1;
    for (int i = 0; i < 30 && WR_n; i++) @(negedge clk);
    check("abort_wr_seen", 32'(WR_n), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    e_esc = 1'b0;
    @(posedge clk);
    #1;
    check("abort_wr_n",  32'(WR_n),  32'd1);
    check("abort_cs_n",  32'(CS_n),  32'd1);
    check("abort_ad_oe", 32'(AD_oe), 32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full 7-field sequence; the last field keeps E_esc high afterwards.
    dir_cnt  = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    for (int f = 0; f < 7; f++) run_field(f, f == 6);
`ifdef RTC_WR_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("timeout_err",  32'(err),  32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    e_esc = 1'b0;
`else
    repeat (20) @(negedge clk);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_err",  32'(err),  32'd0);
    e_esc = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("seq_done_pulses", 32'(done_cnt), 32'd7);
    check("seq_wr_pulses",   32'(wr_cnt),   32'd14);
    check("seq_dir_pulses",  32'(dir_cnt),  32'd7);
    check("seq_end_idle",    32'(busy),     32'd0);

    // Minimum timing: every timed state lasts one cycle, NEXT in the 11th cycle.
    wrlow   = 0;
    cslow   = 0;
    done_at = -1;
    start   = cyc + 1;
    e2      = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!WR_n2) begin
        wrlow++;
        check("fast_ad_out", 32'(AD_out2), 32'h5A);
      end
      if (!CS_n2) cslow++;
      if (cambio2) begin
        done_at = cyc;
        break;
      end
    end
    check("fast_done_cycle", 32'(done_at - start), 32'd10);
    check("fast_wr_cycles",  32'(wrlow),           32'd2);
    check("fast_cs_cycles",  32'(cslow),           32'd8);
    @(negedge clk);
    e2 = 1'b0;
    repeat (2) @(negedge clk);
    check("fast_idle", 32'(busy2), 32'd0);

    check("wr_queue_empty",   32'(wr_q.size()),   32'd0);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
